// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths, types and reader states for the 8x8 register file.
// Rev 1.0
`default_nettype none

package reg_file_pkg;

  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Register index after a, wrapping NUM_REGS-1 back to 0.
  function automatic reg_addr_t next_addr(input reg_addr_t a);
    return a + reg_addr_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_file.sv
// register_file: 8x8 registers, one synchronous write port, two combinational read ports.
// Rev 1.0
`default_nettype none

module register_file
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] d_out_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] d_out_b
);

  reg_data_t regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Reads see the contents before any write landing on the same edge.
  assign d_out_a = regs_q[rd_addr_a];
  assign d_out_b = regs_q[rd_addr_b];

endmodule

`default_nettype wire

// File: rtl/reg_file_reader.sv
// reg_file_reader: walks an address range on one register_file read port and streams the bytes out.
// Rev 1.0
`default_nettype none

module reg_file_reader
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  state_t    state_q,   state_d;
  reg_addr_t ptr_q,     ptr_d;
  reg_addr_t last_q,    last_d;
  logic      m_valid_q, m_valid_d;
  reg_data_t m_data_q,  m_data_d;
  logic      m_last_q,  m_last_d;
  logic      done_q,    done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      last_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = first_addr;
          last_d  = last_addr;
          state_d = FETCH;
        end
      end

      FETCH: begin
        m_data_d  = rd_data;
        m_last_d  = (ptr_q == last_q);
        m_valid_d = 1'b1;
        state_d   = SEND;
      end

      SEND: begin
        // Beat stays frozen until the consumer takes it.
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            m_last_d = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            ptr_d   = next_addr(ptr_q);
            state_d = FETCH;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_addr = ptr_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_reader.sv
// tb_reg_file_reader: drives register_file + reg_file_reader, checks against a beat-level model.
// Rev 1.0
`default_nettype none

module tb_reg_file_reader;
  import reg_file_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, m_ready, wr_en;
  logic [2:0] first_addr, last_addr, rd_addr, wr_addr, rd_addr_a;
  logic [7:0] rd_data, wr_data, m_data, d_out_a;
  logic       m_valid, m_last, busy, done;

  always #5 clk = ~clk;

  register_file u_rf (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .d_out_a   (d_out_a),
    .rd_addr_b (rd_addr),
    .d_out_b   (rd_data)
  );

  reg_file_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Beat-level model: a dump is a list of n addresses starting at base;
  // each beat needs one fetch cycle before it is offered.
  logic [7:0] mem [8];
  bit         m_on = 1'b0;
  bit         mem_ok = 1'b0;
  bit         active = 1'b0;
  bit         fetch_pend = 1'b0;
  int         base, n, idx;
  logic       e_valid, e_last, e_done;
  logic [2:0] e_rdaddr;
  logic [7:0] e_data;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      active = 0; fetch_pend = 0;
      e_valid = 0; e_last = 0; e_done = 0; e_rdaddr = 0; e_data = 0;
      m_on = 1;
    end else begin
      e_done = 0;
      if (!active) begin
        if (start) begin
          active = 1; fetch_pend = 1; idx = 0;
          base = int'(first_addr);
          n = ((int'(last_addr) - int'(first_addr) + 8) % 8) + 1;
          e_rdaddr = first_addr;
        end
      end else if (fetch_pend) begin
        e_data = mem[e_rdaddr];
        e_valid = 1;
        e_last = (idx == n - 1);
        fetch_pend = 0;
      end else if (m_ready) begin
        e_valid = 0;
        if (idx == n - 1) begin
          e_last = 0; e_done = 1; active = 0;
        end else begin
          idx++;
          e_rdaddr = 3'((base + idx) % 8);
          fetch_pend = 1;
        end
      end
    end
    if (wr_en) mem[wr_addr] = wr_data;
  end

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      chk("m_valid", {31'd0, m_valid}, {31'd0, e_valid});
      chk("m_last", {31'd0, m_last}, {31'd0, e_last});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("busy", {31'd0, busy}, {31'd0, active});
      chk("rd_addr", {29'd0, rd_addr}, {29'd0, e_rdaddr});
      if (e_valid) chk("m_data", {24'd0, m_data}, {24'd0, e_data});
      if (mem_ok) chk("d_out_a", {24'd0, d_out_a}, {24'd0, mem[rd_addr_a]});
    end
  end

  // Beat capture and timing bookkeeping, sampled mid-cycle.
  logic [8:0] got_q [$];
  int cyc = 0, first_valid_cyc = -1, done_cyc = -1, done_cnt = 0, busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_q.delete();
    first_valid_cyc = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic do_start(input logic [2:0] f, input logic [2:0] l);
    start = 1; first_addr = f; last_addr = l;
    tick();
    start = 0; first_addr = ~f; last_addr = ~l;
  endtask

  task automatic wait_done(input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", maxc);
    end
    tick();
  endtask

  task automatic check_beats(input string nm, input logic [8:0] exp [$]);
    chk({nm, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk($sformatf("%s_beat%0d", nm, i), {23'd0, got_q[i]}, {23'd0, exp[i]});
  endtask

  logic [8:0] exp_q [$];

  initial begin
    reset = 1; start = 0; m_ready = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
    first_addr = 0; last_addr = 0; rd_addr_a = 3'd5;
    tick();
    @(negedge clk);
    chk("rst_rd_addr", {29'd0, rd_addr}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_m_last", {31'd0, m_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    tick();
    reset = 0;

    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 8'h10 + 8'(i);
      tick();
    end
    wr_en = 0;
    mem_ok = 1;

    // Full range with m_ready held high.
    clear_log();
    do_start(3'd0, 3'd7);
    wait_done(40);
    exp_q = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014, 9'h015, 9'h016, 9'h117};
    check_beats("full", exp_q);
    chk("full_span", done_cyc - first_valid_cyc + 1, 32'd16);
    chk("full_done_cnt", done_cnt, 32'd1);

    // Wrapping range 6..1.
    clear_log();
    do_start(3'd6, 3'd1);
    wait_done(30);
    exp_q = '{9'h016, 9'h017, 9'h010, 9'h111};
    check_beats("wrap", exp_q);

    // Single register.
    clear_log();
    do_start(3'd3, 3'd3);
    wait_done(20);
    exp_q = '{9'h113};
    check_beats("single", exp_q);
    chk("single_busy", busy_cnt, 32'd2);

    // Start raised in the done cycle is taken straight away.
    do_start(3'd4, 3'd4);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    clear_log();
    start = 1; first_addr = 3'd5; last_addr = 3'd5;
    tick();
    start = 0;
    wait_done(20);
    exp_q = '{9'h115};
    check_beats("back2back", exp_q);

    // Backpressure on the second beat of a 0..2 dump.
    clear_log();
    do_start(3'd0, 3'd2);
    repeat (2) @(posedge clk);
    #1 m_ready = 0;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, m_valid}, 32'd1);
      chk("stall_data", {24'd0, m_data}, 32'h11);
      chk("stall_rd_addr", {29'd0, rd_addr}, 32'd1);
    end
    @(posedge clk);
    #1 m_ready = 1;
    wait_done(30);
    exp_q = '{9'h010, 9'h011, 9'h112};
    check_beats("stall", exp_q);

    // Write to reg 2 on the edge that fetches it: old value streamed.
    clear_log();
    do_start(3'd2, 3'd2);
    wr_en = 1; wr_addr = 3'd2; wr_data = 8'hAA;
    tick();
    wr_en = 0;
    wait_done(20);
    exp_q = '{9'h112};
    check_beats("wr_race", exp_q);
    clear_log();
    do_start(3'd2, 3'd2);
    wait_done(20);
    exp_q = '{9'h1AA};
    check_beats("wr_after", exp_q);

    // Start pulsed mid-dump is ignored.
    clear_log();
    do_start(3'd0, 3'd3);
    tick();
    start = 1; first_addr = 3'd5; last_addr = 3'd5;
    tick();
    start = 0;
    wait_done(30);
    repeat (3) tick();
    exp_q = '{9'h010, 9'h011, 9'h0AA, 9'h113};
    check_beats("ignore_start", exp_q);
    chk("ignore_done_cnt", done_cnt, 32'd1);

    // Reset while beat 0 is on offer.
    clear_log();
    do_start(3'd0, 3'd7);
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("abort_valid", {31'd0, m_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_data", {24'd0, m_data}, 32'd0);
    tick();
    clear_log();
    do_start(3'd0, 3'd7);
    wait_done(40);
    exp_q = '{9'h010, 9'h011, 9'h0AA, 9'h013, 9'h014, 9'h015, 9'h016, 9'h117};
    check_beats("after_abort", exp_q);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
